// File: rtl/jts16_scr_rs_if.sv
// Memory-side bundle for the scroll layer: row-scroll table, tile map and tile graphics
// read ports, each with its own request/acknowledge pair.
interface jts16_scr_rs_if;
    logic        rs_cs;
    logic [ 7:0] rs_addr;
    logic [15:0] rs_data;
    logic        rs_ok;
    logic        map_cs;
    logic [13:0] map_addr;
    logic [15:0] map_data;
    logic        map_ok;
    logic        scr_cs;
    logic [15:0] scr_addr;
    logic [31:0] scr_data;
    logic        scr_ok;

    modport master (
        output rs_cs, rs_addr, map_cs, map_addr, scr_cs, scr_addr,
        input  rs_data, rs_ok, map_data, map_ok, scr_data, scr_ok
    );
    modport slave (
        input  rs_cs, rs_addr, map_cs, map_addr, scr_cs, scr_addr,
        output rs_data, rs_ok, map_data, map_ok, scr_data, scr_ok
    );
endinterface

// File: rtl/jts16_scr_rs.sv
// System 16 scroll tilemap layer with selectable bit depth and an optional per-line
// row-scroll table fetched during horizontal blank. One pixel per pxl_cen.
module jts16_scr_rs #(
    parameter int         PXL_DLY  = 0,
    parameter int         BPP      = 3,
    parameter logic [8:0] RS_HPOS  = 9'h1A0,
    parameter logic [8:0] RS_APPLY = 9'h000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pxl_cen,
    input  logic [15:0]       pages,
    input  logic [15:0]       hscr,
    input  logic [15:0]       vscr,
    input  logic              rowscr_en,
    input  logic [ 8:0]       vdump,
    input  logic [ 8:0]       hdump,
    output logic [7+BPP:0]    pxl,
    jts16_scr_rs_if.master    mem
);
    typedef enum logic [0:0] {RS_IDLE, RS_REQ} rs_state_t;
    typedef enum logic [1:0] {T_IDLE, T_MAP, T_GFX} t_state_t;
    typedef logic [BPP-1:0][7:0] planes_t;

    rs_state_t  rs_st_q, rs_st_d;
    t_state_t   t_st_q, t_st_d;
    logic       rs_cs_q, rs_cs_d, map_cs_q, map_cs_d, scr_cs_q, scr_cs_d;
    logic       valid_p_q, valid_p_d;
    logic [7:0] rs_addr_q, rs_addr_d, attr_p_q, attr_p_d, attr_q, attr_d;
    logic [8:0] rs_latched_q, rs_latched_d, hs_line_q, hs_line_d;
    logic [13:0] map_addr_q, map_addr_d;
    logic [15:0] scr_addr_q, scr_addr_d;
    planes_t    gfx_p_q, gfx_p_d, shift_q, shift_d, planes;
    logic [BPP-1:0] colour;

    logic [9:0] hsum;
    logic [8:0] vsum;
    logic [2:0] page;
    logic       apply, boundary, scr_hit;
    logic       unused_bits;

    // hov/vov pick one of the four pages of the 2x2 virtual screen
    assign hsum = {1'b0, hdump} + 10'h100 - {1'b0, hs_line_q} + 10'(PXL_DLY);
    assign vsum = {1'b0, vdump[7:0]} + {1'b0, vscr[7:0]};

    always_comb begin
        case ({vsum[8], ~hsum[9]})
            2'b11:   page = pages[14:12];
            2'b10:   page = pages[10:8];
            2'b01:   page = pages[6:4];
            default: page = pages[2:0];
        endcase
    end

    always_comb begin
        for (int p = 0; p < BPP; p++) begin
            planes[p] = mem.scr_data[8*p +: 8];
            colour[p] = shift_q[p][7];
        end
    end

    assign apply    = pxl_cen && (hdump == RS_APPLY);
    assign boundary = pxl_cen && (hsum[2:0] == 3'd0);
    assign scr_hit  = (t_st_q == T_GFX) && scr_cs_q && mem.scr_ok;

    // NOTE: every signal gets its hold value first so no path through the
    // branches below leaves one unassigned, which would infer a latch.
    always_comb begin
        rs_st_d      = rs_st_q;
        rs_cs_d      = rs_cs_q;
        rs_addr_d    = rs_addr_q;
        rs_latched_d = rs_latched_q;
        hs_line_d    = hs_line_q;
        t_st_d       = t_st_q;
        map_cs_d     = map_cs_q;
        map_addr_d   = map_addr_q;
        scr_cs_d     = scr_cs_q;
        scr_addr_d   = scr_addr_q;
        attr_p_d     = attr_p_q;
        gfx_p_d      = gfx_p_q;
        valid_p_d    = valid_p_q;
        shift_d      = shift_q;
        attr_d       = attr_q;

        if (apply) hs_line_d = rowscr_en ? rs_latched_q : hscr[8:0];

        case (rs_st_q)
            RS_IDLE: if (pxl_cen && hdump == RS_HPOS && rowscr_en) begin
                rs_st_d   = RS_REQ;
                rs_cs_d   = 1'b1;
                rs_addr_d = vdump[7:0] + 8'd1;
            end
            RS_REQ: begin
                if (rs_cs_q && mem.rs_ok) begin
                    rs_latched_d = mem.rs_data[8:0];
                    rs_cs_d      = 1'b0;
                    rs_st_d      = RS_IDLE;
                end else if (apply) begin
                    rs_cs_d = 1'b0;
                    rs_st_d = RS_IDLE;
                end
            end
            default: rs_st_d = RS_IDLE;
        endcase

        case (t_st_q)
            T_MAP: if (map_cs_q && mem.map_ok) begin
                attr_p_d   = mem.map_data[12:5];
                scr_addr_d = {mem.map_data[13], mem.map_data[11:0], vsum[2:0]};
                map_cs_d   = 1'b0;
                scr_cs_d   = 1'b1;
                t_st_d     = T_GFX;
            end
            T_GFX: if (scr_hit) begin
                gfx_p_d   = planes;
                valid_p_d = 1'b1;
                scr_cs_d  = 1'b0;
                t_st_d    = T_IDLE;
            end
            default: ;
        endcase

        // Tile boundary wins over any pending fetch; graphics landing on this very
        // edge still count as valid.
        if (boundary) begin
            if (valid_p_q || scr_hit) begin
                shift_d = scr_hit ? planes : gfx_p_q;
                attr_d  = attr_p_q;
            end else begin
                shift_d = '0;
                attr_d  = '0;
            end
            valid_p_d  = 1'b0;
            scr_cs_d   = 1'b0;
            map_cs_d   = 1'b1;
            map_addr_d = {page, vsum[7:3], hsum[8:3] ^ 6'h20};
            t_st_d     = T_MAP;
        end else if (pxl_cen) begin
            for (int p = 0; p < BPP; p++) shift_d[p] = {shift_q[p][6:0], 1'b0};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_st_q      <= RS_IDLE;
            rs_cs_q      <= 1'b0;
            rs_addr_q    <= '0;
            rs_latched_q <= '0;
            hs_line_q    <= '0;
            t_st_q       <= T_IDLE;
            map_cs_q     <= 1'b0;
            map_addr_q   <= '0;
            scr_cs_q     <= 1'b0;
            scr_addr_q   <= '0;
            attr_p_q     <= '0;
            gfx_p_q      <= '0;
            valid_p_q    <= 1'b0;
            shift_q      <= '0;
            attr_q       <= '0;
        end else begin
            rs_st_q      <= rs_st_d;
            rs_cs_q      <= rs_cs_d;
            rs_addr_q    <= rs_addr_d;
            rs_latched_q <= rs_latched_d;
            hs_line_q    <= hs_line_d;
            t_st_q       <= t_st_d;
            map_cs_q     <= map_cs_d;
            map_addr_q   <= map_addr_d;
            scr_cs_q     <= scr_cs_d;
            scr_addr_q   <= scr_addr_d;
            attr_p_q     <= attr_p_d;
            gfx_p_q      <= gfx_p_d;
            valid_p_q    <= valid_p_d;
            shift_q      <= shift_d;
            attr_q       <= attr_d;
        end
    end

    assign mem.rs_cs    = rs_cs_q;
    assign mem.rs_addr  = rs_addr_q;
    assign mem.map_cs   = map_cs_q;
    assign mem.map_addr = map_addr_q;
    assign mem.scr_cs   = scr_cs_q;
    assign mem.scr_addr = scr_addr_q;
    assign pxl          = {attr_q, colour};

    assign unused_bits = ^{pages[15], pages[11], pages[7], pages[3], hscr[15:9], vscr[15:8],
                           vdump[8], mem.rs_data[15:9], mem.map_data[15:14], mem.scr_data};
endmodule

// File: doc/jts16_scr_rs.md
# jts16_scr_rs

Next-generation Sega System 16 scroll (background/foreground) tilemap layer. It generalises the fixed 3bpp single-scroll layer with:
- a parametrised bit depth;
- an optional per-line row-scroll table fetched during horizontal blank;
- explicit request/acknowledge handshakes on every SDRAM/VRAM port, including defined behaviour when data arrives late.

It sits between the MMR/VRAM block and the tilemap mixer and produces one pixel per `pxl_cen`.

## Interface
Parameters:
- `PXL_DLY`, 0: signed horizontal pre-fetch offset added to `hdump`.
- `BPP`, 3: bits per pixel, 3 or 4. Sets the `pxl` width and the planes used from `scr_data`.
- `RS_HPOS`, 9'h1A0: `hdump` value at which the row-scroll fetch for the next line starts.
- `RS_APPLY`, 9'h000: `hdump` value at which the fetched row scroll becomes active.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pxl_cen`, in, 1: pixel clock enable.
- `pages`, in, 16: four 3-bit page selectors at bits [14:12], [10:8], [6:4], [2:0].
- `hscr`, in, 16: global horizontal scroll. Bits [8:0] are used.
- `vscr`, in, 16: vertical scroll. Bits [7:0] are used.
- `rowscr_en`, in, 1: 1 selects per-line scroll from the table instead of `hscr`.
- `rs_cs`, out, 1: row-scroll read request.
- `rs_addr`, out, 8: row-scroll table line index.
- `rs_data`, in, 16: row-scroll entry. Bits [8:0] are used.
- `rs_ok`, in, 1: row-scroll acknowledge.
- `map_cs`, out, 1: tile map read request.
- `map_addr`, out, 14: {page[2:0], row[4:0], col[5:0]}.
- `map_data`, in, 16: map word.
- `map_ok`, in, 1: map acknowledge.
- `scr_cs`, out, 1: tile graphics read request.
- `scr_addr`, out, 16: {code[12:0], line-in-tile[2:0]}.
- `scr_data`, in, 32: planes, one per byte, MSB first. Plane p is at bits [8p+7:8p].
- `scr_ok`, in, 1: graphics acknowledge.
- `vdump`, in, 9: current line.
- `hdump`, in, 9: current column.
- `pxl`, out, 8+BPP: {prio, palette[6:0], colour[BPP-1:0]}.

## Operation
Position arithmetic (combinational, 10-bit):
- {hov, hpos} = {0, hdump} + 0x100 − {0, hs_line} + PXL_DLY.
- {vov, vpos} = vdump[7:0] + vscr[7:0].
- Page selection by {vov, ~hov}:
  - 11 → pages[14:12]
  - 10 → pages[10:8]
  - 01 → pages[6:4]
  - 00 → pages[2:0]
- map_addr = {page, vpos[7:3], hpos[8:3] ^ 6'h20}.

hs_line register:
- Loaded at `RS_APPLY` with `rs_latched` if `rowscr_en`, otherwise with hscr[8:0].
- Updated only at `RS_APPLY`; constant for the rest of the line.

Row-scroll FSM (advances on `pxl_cen` or `rs_ok`):
- RS_IDLE → RS_REQ on hdump==RS_HPOS with rowscr_en=1. Sets rs_addr=vdump[7:0]+1 (wraps 0xFF→0x00) and rs_cs=1.
- RS_REQ → RS_IDLE on rs_ok: rs_latched ← rs_data[8:0], rs_cs ← 0.
- RS_REQ → RS_IDLE on reaching RS_APPLY without rs_ok: request is cancelled, rs_latched keeps its previous value.
- rowscr_en=0 never leaves RS_IDLE.

Tile fetch FSM (one tile per 8 pixels):
- T_IDLE → T_MAP at a `pxl_cen` with hpos[2:0]==0: map_addr latched, map_cs=1.
- T_MAP → T_GFX on map_ok:
  - code ← {map_data[13], map_data[11:0]}
  - attr_p ← map_data[12:5]
  - scr_addr ← {code, vpos[2:0]}
  - map_cs=0, scr_cs=1
- T_GFX → T_IDLE on scr_ok: gfx_p ← planes 0..BPP−1, valid_p ← 1, scr_cs=0.
- Any state at a `pxl_cen` with hpos[2:0]==0 (tile boundary):
  - valid_p=1: shift registers ← gfx_p, attr ← attr_p.
  - valid_p=0 (miss): shift registers ← 0, attr ← 0.
  - In both cases, clear valid_p, drop outstanding cs, and start a new T_MAP.
- Between boundaries each plane shifts left by 1 per `pxl_cen`. colour[p] is the MSB of plane p.

pxl = {attr, colour}.

## Timing
- Reset: all outputs 0. Both FSMs go to idle, and hs_line, rs_latched and valid_p are 0.
- Requests: cs rises in the same cycle as the triggering `pxl_cen` edge. A request is held until its ok, or until it is cancelled at a boundary.
- Acknowledge: an ok is accepted only while its cs=1. ok with cs=0 is ignored.
- map_ok and scr_ok can each arrive any number of `clk` cycles after cs. The data for a tile must complete within 8 `pxl_cen` periods, otherwise the tile is a miss.
- Latency: the map request for tile N is issued at boundary N. Its pixels appear on `pxl` from boundary N+1, for 8 `pxl_cen`.
- Simultaneous scr_ok and boundary in the same cycle: the data counts as valid and is loaded.
- Reset deassertion mid-line: first valid tile output one boundary after the first fetch completes.

## Test plan
- Reset: hold rst_n=0 with `pxl_cen` toggling → pxl=0, map_cs=scr_cs=rs_cs=0, map_addr=0.
- Basic tile, BPP=3, hscr=0, vscr=0, pages=0x0000, zero-latency ok:
  - Map word 0x2FE1 → code=0x1FE1, attr=0x7F.
  - scr_data plane0=0x80, others 0 → first pixel colour=3'b001, next 7 pixels colour=0.
- Page wrap: hscr=0x0001, vscr=0x10, vdump=0xF8 → vov=1; check map_addr[13:11]=pages[14:12] versus pages[10:8] across the hov transition.
- Row scroll:
  - rowscr_en=1, rs_data=0x0008 for line vdump+1 → that line is shifted by exactly one tile relative to rowscr_en=0.
  - rs_ok withheld past RS_APPLY → previous scroll kept and rs_cs dropped.
- Miss: delay scr_ok by 9 `pxl_cen` → that tile outputs pxl=0 for 8 pixels; the following tile is correct.
- BPP=4: plane3=0xFF, others 0 → colour=4'b1000 for all 8 pixels, and pxl width is 12.
